// File: rtl/amm_burst_master_if.sv
// rtl/amm_burst_master_if.sv - Avalon-MM bus bundle between the burst master and the memory under test
interface amm_burst_master_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 11
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [BURST_W-1:0]  burstcount;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, read, write, byteenable, burstcount, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, burstcount, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/amm_burst_master.sv
// rtl/amm_burst_master.sv - Command-driven Avalon-MM burst master
// Splits each read/write command into bursts of at most MAX_BURST words.
module amm_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 11,
  parameter int LEN_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_words,
  output logic                cmd_done,
  input  logic                wr_valid,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_ready,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  amm_burst_master_if.master  amm
);
  localparam int BYTES     = DATA_W / 8;
  localparam int MAX_BURST = 2 ** (BURST_W - 1);
  localparam int CMP_W     = (LEN_W > BURST_W) ? LEN_W : BURST_W;

  typedef enum logic [2:0] {
    IDLE,
    WR_BURST,
    RD_REQ,
    RD_WAIT,
    DONE
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic [LEN_W-1:0]    remaining, remaining_d;
  logic [BURST_W-1:0]  len, len_d;
  logic [BURST_W-1:0]  beat, beat_d;

  logic                wr_beat;
  logic                rd_beat;
  logic                last_beat;
  logic [LEN_W-1:0]    rem_after;
  logic [ADDR_W-1:0]   addr_after;

  function automatic logic [BURST_W-1:0] burst_len(input logic [LEN_W-1:0] rem);
    if (CMP_W'(rem) > CMP_W'(MAX_BURST)) begin
      return BURST_W'(MAX_BURST);
    end
    return BURST_W'(rem);
  endfunction

  assign wr_beat    = (state == WR_BURST) && wr_valid && !amm.waitrequest;
  assign rd_beat    = (state == RD_WAIT) && amm.readdatavalid;
  assign last_beat  = (beat == len - 1'b1);
  assign rem_after  = remaining - LEN_W'(len);
  // Byte address advances by a whole burst; wraps silently at 2**ADDR_W.
  assign addr_after = addr + ADDR_W'(len) * ADDR_W'(BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d          = state;
    addr_d           = addr;
    remaining_d      = remaining;
    len_d            = len;
    beat_d           = beat;
    cmd_ready        = 1'b0;
    cmd_done         = 1'b0;
    wr_ready         = 1'b0;
    amm.address      = '0;
    amm.read         = 1'b0;
    amm.write        = 1'b0;
    amm.byteenable   = '0;
    amm.burstcount   = '0;
    amm.writedata    = '0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          remaining_d = cmd_words;
          len_d       = burst_len(cmd_words);
          beat_d      = '0;
          if (cmd_words == '0) begin
            state_d = DONE;
          end else if (cmd_op) begin
            state_d = RD_REQ;
          end else begin
            state_d = WR_BURST;
          end
        end
      end
      WR_BURST: begin
        // Address and burstcount stay put across wr_valid gaps and waitrequest stalls.
        amm.address    = addr;
        amm.burstcount = len;
        amm.write      = wr_valid;
        amm.writedata  = wr_data;
        amm.byteenable = wr_valid ? '1 : '0;
        wr_ready       = wr_beat;
      end
      RD_REQ: begin
        amm.address    = addr;
        amm.burstcount = len;
        amm.read       = 1'b1;
        if (!amm.waitrequest) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
      end
      DONE: begin
        cmd_done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Shared end-of-burst bookkeeping for both directions.
    if (wr_beat || rd_beat) begin
      if (last_beat) begin
        beat_d      = '0;
        remaining_d = rem_after;
        addr_d      = addr_after;
        len_d       = burst_len(rem_after);
        if (rem_after == '0) begin
          state_d = DONE;
        end else if (state == WR_BURST) begin
          state_d = WR_BURST;
        end else begin
          state_d = RD_REQ;
        end
      end else begin
        beat_d = beat + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      len       <= '0;
      beat      <= '0;
    end else begin
      addr      <= addr_d;
      remaining <= remaining_d;
      len       <= len_d;
      beat      <= beat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_beat;
      if (rd_beat) begin
        rd_data <= amm.readdata;
      end
    end
  end
endmodule

// File: tb/tb_amm_burst_master.sv
// tb/tb_amm_burst_master.sv - Directed self-checking bench for amm_burst_master
module tb_amm_burst_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_words;
  logic        cmd_done;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;

  int passes = 0;
  int total  = 0;

  amm_burst_master_if #(.ADDR_W(32), .DATA_W(32), .BURST_W(11)) amm ();

  amm_burst_master #(
    .ADDR_W(32), .DATA_W(32), .BURST_W(11), .LEN_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_words (cmd_words),
    .cmd_done  (cmd_done),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .amm       (amm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int minb(input int r);
    return (r > 1024) ? 1024 : r;
  endfunction

  task automatic issue(input logic op, input logic [31:0] a, input logic [15:0] n);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_words = n;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Drives a write command; waitrequest high for cycles [ws,ws+wl), wr_valid low for [gs,gs+gl).
  task automatic run_write(input logic [31:0] a, input int n, input int ws, input int wl,
                           input int gs, input int gl);
    int  acc = 0;
    bit  fin = 0;
    bit  wt, wv;
    issue(1'b0, a, n[15:0]);
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      wt = (cyc >= ws) && (cyc < ws + wl);
      wv = !((cyc >= gs) && (cyc < gs + gl));
      amm.waitrequest = wt;
      wr_valid        = wv;
      wr_data         = 32'hD000_0000 + acc;
      @(negedge clk);
      chk("wr_write", amm.write, wv && (acc < n));
      chk("wr_ready", wr_ready, wv && !wt && (acc < n));
      chk("wr_no_read", amm.read, 0);
      chk("wr_done", cmd_done, acc == n);
      if (wv && acc < n) begin
        chk("wr_address", amm.address, a + (acc / 1024) * 4096);
        chk("wr_burstcount", amm.burstcount, minb(n - (acc / 1024) * 1024));
        chk("wr_writedata", amm.writedata, 32'hD000_0000 + acc);
        chk("wr_byteenable", amm.byteenable, 4'hF);
      end
      if (acc == n) fin = 1;
      else if (wv && !wt) acc++;
      @(posedge clk); #1;
    end
    chk("wr_complete", fin, 1);
    wr_valid = 1'b0;
    amm.waitrequest = 1'b0;
    @(negedge clk);
    chk("wr_done_single", cmd_done, 0);
    chk("wr_ready_after", cmd_ready, 1);
    @(posedge clk); #1;
  endtask

  // Drives a read command with a slave that returns data = global beat index,
  // one idle cycle after each accepted request; waitrequest high for wl cycles per request.
  task automatic run_read(input logic [31:0] a, input int n, input int wl,
                          input int exp_bursts, input int exp_rd_cycles);
    int          phase = 0;
    int          req_cyc = 0, lat = 0, bcnt = 0, delivered = 0;
    int          rem = n, len, bursts = 0, rd_cycles = 0;
    logic [31:0] baddr = a;
    bit          prev_v = 0, rv, wt, fin = 0;
    logic [31:0] prev_d = '0;
    len = minb(rem);
    issue(1'b1, a, n[15:0]);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      wt = (phase == 0) && (req_cyc < wl);
      rv = (phase == 1) && (lat >= 1);
      amm.waitrequest   = wt;
      amm.readdatavalid = rv;
      amm.readdata      = delivered;
      @(negedge clk);
      chk("rd_valid", rd_valid, prev_v);
      if (prev_v) chk("rd_data", rd_data, prev_d);
      chk("rd_read", amm.read, phase == 0);
      chk("rd_no_write", amm.write, 0);
      chk("rd_done", cmd_done, phase == 2);
      if (phase == 0) begin
        chk("rd_address", amm.address, baddr);
        chk("rd_burstcount", amm.burstcount, len);
        if (bursts == 0 && amm.read === 1'b1) rd_cycles++;
      end
      prev_v = rv;
      prev_d = delivered;
      if (phase == 2) begin
        fin = 1;
      end else if (phase == 0) begin
        req_cyc++;
        if (!wt) begin
          phase = 1; lat = 0; bcnt = 0; bursts++;
        end
      end else begin
        lat++;
        if (rv) begin
          delivered++;
          bcnt++;
          if (bcnt == len) begin
            rem   = rem - len;
            baddr = baddr + len * 4;
            if (rem == 0) phase = 2;
            else begin
              phase = 0; req_cyc = 0; len = minb(rem);
            end
          end
        end
      end
      @(posedge clk); #1;
    end
    amm.readdatavalid = 1'b0;
    amm.waitrequest   = 1'b0;
    chk("rd_complete", fin, 1);
    chk("rd_beats", delivered, n);
    chk("rd_bursts", bursts, exp_bursts);
    chk("rd_read_cycles", rd_cycles, exp_rd_cycles);
    @(negedge clk);
    chk("rd_done_single", cmd_done, 0);
    chk("rd_ready_after", cmd_ready, 1);
    chk("rd_valid_after", rd_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1;
    cmd_valid = 0; cmd_op = 0; cmd_addr = '0; cmd_words = '0;
    wr_valid = 0; wr_data = '0;
    amm.readdata = '0; amm.readdatavalid = 0; amm.waitrequest = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_read", amm.read, 0);
    chk("rst_write", amm.write, 0);
    chk("rst_burstcount", amm.burstcount, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single 4-word write burst, no stalls.
    run_write(32'h100, 4, 0, 0, 0, 0);
    // Write stalled by waitrequest on beat 0 and a wr_valid gap mid-burst.
    run_write(32'h200, 6, 0, 3, 5, 2);

    // Zero-length command: done pulse only.
    issue(1'b0, 32'h80, 16'd0);
    @(negedge clk);
    chk("zero_done", cmd_done, 1);
    chk("zero_ready", cmd_ready, 0);
    chk("zero_write", amm.write, 0);
    chk("zero_read", amm.read, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_done_single", cmd_done, 0);
    chk("zero_ready_after", cmd_ready, 1);
    @(posedge clk); #1;

    // 2500 words split into 1024 + 1024 + 452.
    run_read(32'h0, 2500, 0, 3, 1);
    // Request held through 5 waitrequest cycles.
    run_read(32'h400, 3, 5, 1, 6);

    // Stray readdatavalid in IDLE.
    amm.readdatavalid = 1'b1;
    amm.readdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    amm.readdatavalid = 1'b0;
    @(negedge clk);
    chk("stray_rd_valid", rd_valid, 0);
    chk("stray_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // Reset in the middle of a read burst.
    issue(1'b1, 32'h300, 16'd8);
    amm.waitrequest = 1'b0;
    @(posedge clk); #1;
    amm.readdatavalid = 1'b1;
    amm.readdata = 32'h55;
    @(posedge clk); #1;
    amm.readdata = 32'h56;
    @(negedge clk);
    chk("mid_rd_valid", rd_valid, 1);
    chk("mid_rd_data", rd_data, 32'h55);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_read", amm.read, 0);
    chk("arst_write", amm.write, 0);
    chk("arst_address", amm.address, 0);
    chk("arst_cmd_done", cmd_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_rd_valid", rd_valid, 0);
    amm.readdatavalid = 1'b0;
    @(posedge clk); #1;
    run_write(32'h40, 3, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
